// File: rtl/tt_bist_pkg.sv
// Shared definitions for the Tiny Tapeout BIST harness: controller states,
// stimulus mode encodings and the primitive-polynomial tap masks used by
// both the stimulus LFSR and the response MISR.
package tt_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRST  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_CNT  = 2'd0,
        MODE_LFSR = 2'd1,
        MODE_HOLD = 2'd2,
        MODE_RSVD = 2'd3   // treated exactly like MODE_HOLD
    } mode_e;

    // Tap mask for a left-shifting Fibonacci register of width w: bit i set
    // means state bit i feeds the XOR that enters bit 0. Bit (w-1) is always
    // a tap (the x^w term). Widths outside the table fall back to the top two
    // bits, which keeps the logic well-formed but is not guaranteed maximal.
    function automatic logic [63:0] poly_taps(input int w);
        logic [63:0] taps;
        case (w)
            4:       taps = 64'h0000_0000_0000_000C; // x^4+x^3+1
            8:       taps = 64'h0000_0000_0000_00B8; // x^8+x^6+x^5+x^4+1
            12:      taps = 64'h0000_0000_0000_0829; // x^12+x^6+x^4+x+1
            16:      taps = 64'h0000_0000_0000_D008; // x^16+x^15+x^13+x^4+1
            24:      taps = 64'h0000_0000_00E1_0000; // x^24+x^23+x^22+x^17+1
            32:      taps = 64'h0000_0000_8020_0003; // x^32+x^22+x^2+x+1
            default: taps = (64'h3 << (w - 2));
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/tt_bist_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback
// into bit 0 and XORs the parallel input word in. Clear wins over enable.
// o_sig_next exposes the value the register takes at the coming edge so the
// controller can judge pass/fail on the same edge the final word lands.
module tt_bist_misr
    import tt_bist_pkg::*;
#(
    parameter int             W    = 16,
    parameter logic [W-1:0]   TAPS = W'(poly_taps(W))
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sig,
    output logic [W-1:0] o_sig_next
);

    logic [W-1:0] r_sig;
    logic [W-1:0] w_next;
    logic         w_fb;

    assign w_fb = ^(r_sig & TAPS);

    // Next signature: clear, compress one word, or hold.
    always_comb begin
        w_next = r_sig;
        if (i_clr) begin
            w_next = '0;
        end else if (i_en) begin
            w_next = {r_sig[W-2:0], w_fb} ^ i_data;
        end
    end

    // Signature register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sig <= '0;
        end else begin
            r_sig <= w_next;
        end
    end

    assign o_sig      = r_sig;
    assign o_sig_next = w_next;

endmodule

// File: rtl/tt_bist_harness.sv
// Self-test harness for a Tiny Tapeout user design. A start pulse holds the
// DUT in reset for RST_CYC cycles, streams n_cycles stimulus words (counter,
// LFSR or constant), waits LAT cycles for the DUT pipeline to flush, and
// compresses every response word seen in RUN and DRAIN into a MISR.
// All outputs are registered; o_state exposes the controller state.
module tt_bist_harness
    import tt_bist_pkg::*;
#(
    parameter int                IO_W      = 8,
    parameter int                MISR_W    = 16,
    parameter int                CNT_W     = 16,
    parameter int                RST_CYC   = 4,
    parameter int                LAT       = 2,
    parameter logic [IO_W-1:0]   LFSR_SEED = IO_W'(1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [CNT_W-1:0]  i_n_cycles,
    input  logic [IO_W-1:0]   i_hold_val,
    input  logic [MISR_W-1:0] i_exp_sig,
    output logic              o_dut_rst_n,
    output logic [IO_W-1:0]   o_stim_ui,
    output logic [IO_W-1:0]   o_stim_uio,
    input  logic [IO_W-1:0]   i_resp_uo,
    input  logic [IO_W-1:0]   i_resp_uio,
    input  logic [IO_W-1:0]   i_resp_oe,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [MISR_W-1:0] o_signature,
    output logic [2:0]        o_state
);

    localparam logic [IO_W-1:0]   LFSR_TAPS = IO_W'(poly_taps(IO_W));
    localparam logic [MISR_W-1:0] MISR_TAPS = MISR_W'(poly_taps(MISR_W));

    state_e              r_state;
    state_e              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_n;
    mode_e               r_mode;
    logic [MISR_W-1:0]   r_exp;
    logic [IO_W-1:0]     r_k;
    logic [IO_W-1:0]     r_lfsr;
    logic [IO_W-1:0]     r_stim_ui;
    logic [IO_W-1:0]     r_stim_uio;
    logic                r_dut_rst_n;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                w_go;
    logic                w_load;
    logic                w_misr_en;
    logic [IO_W-1:0]     w_word_ui;
    logic [IO_W-1:0]     w_word_uio;
    logic [2*IO_W-1:0]   w_resp_raw;
    logic [MISR_W-1:0]   w_resp;
    logic [MISR_W-1:0]   w_sig;
    logic [MISR_W-1:0]   w_sig_next;

    // Controller state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. w_go marks an accepted start; w_load marks an edge
    // that begins a RUN cycle and therefore presents a new stimulus word.
    always_comb begin
        w_state_next = r_state;
        w_go         = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_next = ST_DRST;
                    w_go         = 1'b1;
                end
            end
            ST_DRST: begin
                if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                    if (r_n != '0) begin
                        w_state_next = ST_RUN;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = (LAT == 0) ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt == r_n - 1'b1) begin
                    w_state_next = (LAT == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    w_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CNT_W'(LAT - 1)) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Phase counter: restarts at 0 on every state change, counts cycles spent
    // in the current phase.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Run parameters, captured when a start is accepted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_n    <= '0;
            r_mode <= MODE_CNT;
            r_exp  <= '0;
        end else if (w_go) begin
            r_n    <= i_n_cycles;
            r_mode <= mode_e'(i_mode);
            r_exp  <= i_exp_sig;
        end
    end

    // Stimulus generators: reloaded on start, advanced once per word issued.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_k    <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (w_go) begin
            r_k    <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (w_load) begin
            r_k    <= r_k + 1'b1;
            r_lfsr <= {r_lfsr[IO_W-2:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    // Select the stimulus word for the current mode.
    always_comb begin
        w_word_ui  = i_hold_val;
        w_word_uio = i_hold_val;
        case (r_mode)
            MODE_CNT: begin
                w_word_ui  = r_k;
                w_word_uio = ~r_k;
            end
            MODE_LFSR: begin
                w_word_ui  = r_lfsr;
                w_word_uio = {r_lfsr[IO_W-2:0], r_lfsr[IO_W-1]};
            end
            default: begin
                w_word_ui  = i_hold_val;
                w_word_uio = i_hold_val;
            end
        endcase
    end

    // Registered outputs. pass is judged against the signature that lands on
    // the same edge DONE is entered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dut_rst_n <= 1'b1;
            r_stim_ui   <= '0;
            r_stim_uio  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_dut_rst_n <= (w_state_next != ST_DRST);
            r_stim_ui   <= w_load ? w_word_ui  : '0;
            r_stim_uio  <= w_load ? w_word_uio : '0;
            r_busy      <= (w_state_next == ST_DRST) || (w_state_next == ST_RUN) ||
                           (w_state_next == ST_DRAIN);
            r_done      <= (w_state_next == ST_DONE);
            if (w_go) begin
                r_pass <= 1'b0;
            end else if ((w_state_next == ST_DONE) && (r_state != ST_DONE)) begin
                r_pass <= (w_sig_next == r_exp);
            end
        end
    end

    // Response word: uio only counts where the DUT drives it; XOR-fold into
    // the MISR width (pure zero-extension when it already fits).
    assign w_resp_raw = {i_resp_uo, i_resp_uio & i_resp_oe};

    always_comb begin
        w_resp = '0;
        for (int i = 0; i < 2 * IO_W; i++) begin
            w_resp[i % MISR_W] = w_resp[i % MISR_W] ^ w_resp_raw[i];
        end
    end

    assign w_misr_en = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    tt_bist_misr #(
        .W    (MISR_W),
        .TAPS (MISR_TAPS)
    ) u_misr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (w_misr_en),
        .i_clr      (w_go),
        .i_data     (w_resp),
        .o_sig      (w_sig),
        .o_sig_next (w_sig_next)
    );

    assign o_dut_rst_n = r_dut_rst_n;
    assign o_stim_ui   = r_stim_ui;
    assign o_stim_uio  = r_stim_uio;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_signature = w_sig;
    assign o_state     = r_state;

endmodule

// File: doc/tt_bist_harness.md
Name: tt_bist_harness

Overview:
Synthesisable self-test harness that wraps a Tiny Tapeout user design with the standard pin set (ui_in, uo_out, uio_in/out/oe). On start it holds the design in reset, then drives a deterministic stimulus stream for a programmable number of cycles. It compresses every response into a MISR signature and flags pass/fail against an expected value. It is the parametrised, on-chip successor of the simulation-only top-level bench: wider, multi-mode, and usable post-silicon.

Parameters:
IO_W, 8, width of each stimulus/response bus (ui, uio, uo).
MISR_W, 16, signature width; must be >= IO_W and at least 8.
CNT_W, 16, width of the cycle-count register.
RST_CYC, 4, cycles for which dut_rst_n is held low before stimulus; must be >= 1.
LAT, 2, drain cycles after the last stimulus, to flush DUT pipeline latency; may be 0.
LFSR_SEED, 8'h01, non-zero LFSR reset value, IO_W bits.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  single-cycle pulse; accepted only in IDLE or DONE.
mode  in  2  stimulus mode: 0 = counter, 1 = LFSR, 2 = hold; 3 is reserved and behaves as 2.
n_cycles  in  CNT_W  number of stimulus cycles; sampled on start.
hold_val  in  IO_W  constant stimulus value for mode 2.
exp_sig  in  MISR_W  expected signature; sampled on start.
dut_rst_n  out  1  reset output to the DUT.
stim_ui  out  IO_W  drives DUT ui_in.
stim_uio  out  IO_W  drives DUT uio_in.
resp_uo  in  IO_W  DUT uo_out.
resp_uio  in  IO_W  DUT uio_out.
resp_oe  in  IO_W  DUT uio_oe.
busy  out  1  high from the cycle after start until DONE is entered.
done  out  1  high while in DONE.
pass  out  1  valid when done: signature == exp_sig.
signature  out  MISR_W  current MISR value.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets state IDLE, dut_rst_n=1, stim_ui=0, stim_uio=0, busy=0, done=0, pass=0, signature=0, LFSR=LFSR_SEED, counter=0.
- Reset is honoured in every state and aborts a run immediately. No other abort exists.
- FSM states: IDLE, DRST, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch n_cycles, mode, exp_sig; clear the MISR to 0; reload LFSR and counter; go to DRST. done drops in the same edge.
- DRST: dut_rst_n=0 for exactly RST_CYC cycles; stimulus held at 0; then go to RUN.
- RUN: dut_rst_n=1 and one stimulus word per cycle for n_cycles cycles, then go to DRAIN. If n_cycles=0, go straight to DRAIN.
- Stimulus registers:
  - Counter mode: stim_ui=k and stim_uio=~k on the k-th RUN cycle (k from 0, wraps modulo 2^IO_W).
  - LFSR mode: Fibonacci LFSR, for IO_W=8 taps x^8+x^6+x^5+x^4+1, shifting left with the feedback bit into bit 0. stim_ui=lfsr and stim_uio=lfsr rotated left by 1. The first RUN word is LFSR_SEED.
  - Hold mode: stim_ui=stim_uio=hold_val.
  - In DRAIN, DONE and IDLE the stimulus is 0.
- MISR:
  - Updates every cycle in RUN and DRAIN; frozen in all other states.
  - Response word resp = {resp_uo, resp_uio & resp_oe}, zero-extended or XOR-folded into MISR_W bits (fold when 2*IO_W > MISR_W).
  - Update: sig' = {sig[MISR_W-2:0], fb} ^ resp, with fb = XOR of sig bits at primitive-polynomial taps. For MISR_W=16 the taps are 15, 14, 12, 3.
- DRAIN: exactly LAT cycles, then DONE.
- DONE: done=1, busy=0, pass registered on DONE entry, signature stable until the next start.
- start is ignored while busy.
- Counter width: a run with n_cycles = 2^CNT_W - 1 completes correctly.

Decomposition:
- Shared package tt_bist_pkg holds the state enum, mode encodings, and the LFSR/MISR tap constants per width.
- One natural sub-module: tt_bist_misr (parametrised width and taps, enable + clear).

Test Plan:
- Counter mode, n_cycles=5, responses tied to 0 -> dut_rst_n low for 4 cycles; stim_ui sequence 0,1,2,3,4; done after 4+5+2 cycles; signature=16'h0000; pass=1 with exp_sig=0.
- LFSR mode, n_cycles=3, seed 8'h01 -> stim_ui 8'h01, 8'h02, 8'h04; stim_uio 8'h02, 8'h04, 8'h08.
- Loopback resp_uo=stim_ui, resp_oe=0, counter mode, n=4 -> signature equals the golden model value; pass=0 when exp_sig is off by one bit.
- n_cycles=0 -> RUN is skipped; done after RST_CYC+LAT cycles; signature=0.
- rst_n asserted mid-RUN -> all outputs at reset values on the next edge; a fresh start reproduces the identical signature.
- start pulsed while busy -> ignored; the run completes with its original n_cycles.
